// File: rtl/led_pulse_stretcher_pkg.sv
// Shared state encodings and counter-sizing helper for the LED pulse stretcher
// and the switch debounce filter.
package led_pulse_stretcher_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Bits needed to count 0 .. max(a,b)-1; a single bit when both are 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_rising_edge_detect.sv
// Registered 0->1 detector on a clean level; the history register follows the
// level through reset so a level held high across reset release is not an edge.
module rising_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        r_prev <= i_level;
    end

    assign o_rise = i_rst_n & i_level & ~r_prev;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches each rising edge of i_event into a fixed-length LED pulse followed
// by a guaranteed dark gap; edges arriving while busy are counted and replayed.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = 250000,
    parameter int OFF_CYCLES = 250000,
    parameter int PEND_DEPTH = 7
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_event,
    output logic                              o_led,
    output logic                              o_busy,
    output logic [$clog2(PEND_DEPTH+1)-1:0]   o_pending,
    output logic                              o_overflow
);

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || PEND_DEPTH < 1) begin : g_bad_params
        $error("led_pulse_stretcher: ON_CYCLES, OFF_CYCLES and PEND_DEPTH must all be >= 1");
    end

    localparam int unsigned CW = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam int unsigned PW = $clog2(PEND_DEPTH + 1);

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(PEND_DEPTH);

    logic          ev;
    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          led_nx;
    logic [PW-1:0] pend_nx;
    logic          ovf_nx;
    logic          push;

    rising_edge_detect u_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (i_event),
        .o_rise  (ev)
    );

    always_comb begin
        state_nx = state;
        led_nx   = o_led;
        cnt_nx   = cnt + 1'b1;
        pend_nx  = o_pending;
        ovf_nx   = o_overflow;
        push     = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (ev) begin
                    state_nx = ST_ON;
                    led_nx   = 1'b1;
                end
            end
            ST_ON: begin
                push = ev;
                if (cnt == ON_LAST) begin
                    state_nx = ST_GAP;
                    led_nx   = 1'b0;
                    cnt_nx   = '0;
                end
            end
            ST_GAP: begin
                if (cnt == OFF_LAST) begin
                    cnt_nx = '0;
                    if (o_pending != '0) begin
                        // Replay the oldest queued edge; a same-cycle edge takes its slot.
                        state_nx = ST_ON;
                        led_nx   = 1'b1;
                        pend_nx  = o_pending - 1'b1;
                        push     = ev;
                    end else if (ev) begin
                        state_nx = ST_ON;
                        led_nx   = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    push = ev;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                led_nx   = 1'b0;
                cnt_nx   = '0;
            end
        endcase

        if (push) begin
            if (pend_nx < PEND_MAX) begin
                pend_nx = pend_nx + 1'b1;
            end else begin
                ovf_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            o_led      <= 1'b0;
            cnt        <= '0;
            o_pending  <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_nx;
            o_led      <= led_nx;
            cnt        <= cnt_nx;
            o_pending  <= pend_nx;
            o_overflow <= ovf_nx;
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Randomized and directed bench for led_pulse_stretcher against a timeline model
// that tracks each pulse by its start edge rather than by state and counter.
module tb_led_pulse_stretcher;

    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int DEP = 2;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_event = 1'b0;
    logic       o_led;
    logic       o_busy;
    logic [1:0] o_pending;
    logic       o_overflow;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Model: a pulse started at edge s is lit after edges s..s+ON-1, dark after
    // s+ON..s+ON+OFF-1, and edge s+ON+OFF decides whether another pulse starts.
    int unsigned n       = 0;
    bit          m_active = 1'b0;
    int unsigned m_start = 0;
    int          m_pend  = 0;
    bit          m_ovf   = 1'b0;
    bit          m_prev  = 1'b0;

    led_pulse_stretcher #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .PEND_DEPTH (DEP)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_event    (i_event),
        .o_led      (o_led),
        .o_busy     (o_busy),
        .o_pending  (o_pending),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] expv();
        logic led;
        led = m_active && ((n - m_start) < ON);
        return {led, m_active, 2'(m_pend), m_ovf};
    endfunction

    function automatic logic [4:0] gotv();
        return {o_led, o_busy, o_pending, o_overflow};
    endfunction

    task automatic tick();
        bit ev;
        @(posedge clk);
        n++;
        if (!i_rst_n) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_ovf    = 1'b0;
            m_prev   = i_event;
        end else begin
            ev     = i_event && !m_prev;
            m_prev = i_event;
            if (!m_active) begin
                if (ev) begin
                    m_active = 1'b1;
                    m_start  = n;
                end
            end else if (n == m_start + ON + OFF) begin
                if (m_pend > 0) begin
                    m_pend  = m_pend - 1 + (ev ? 1 : 0);
                    m_start = n;
                end else if (ev) begin
                    m_start = n;
                end else begin
                    m_active = 1'b0;
                end
            end else if (ev) begin
                if (m_pend < DEP) m_pend++;
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drain();
        i_event = 1'b0;
        for (int i = 0; i < 60 && m_active; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_event = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (gotv() !== 5'b0) $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, gotv(), 5'b0);
            else passed++;
        end
        i_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (gotv() !== 5'b0 || expv() !== 5'b0)
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, gotv(), 5'b0);
            else passed++;
        end
        drain();
    endtask

    task automatic test_single();
        for (int i = 0; i < 14; i++) begin
            i_event = (i >= 2 && i < 4);
            tick();
            total++;
            if (gotv() !== expv()) $display("FAIL single cyc=%0d got=%b exp=%b", i, gotv(), expv());
            else passed++;
        end
        drain();
    endtask

    task automatic test_two_events();
        bit lv [0:3] = '{1, 0, 1, 0};
        for (int i = 0; i < 20; i++) begin
            i_event = (i < 4) ? lv[i] : 1'b0;
            tick();
            total++;
            if (gotv() !== expv()) $display("FAIL two_events cyc=%0d got=%b exp=%b", i, gotv(), expv());
            else passed++;
        end
        drain();
    endtask

    task automatic test_overflow();
        int  pulses = 0;
        bit  prev_led = 1'b0;
        for (int i = 0; i < 40; i++) begin
            i_event = (i < 8) && (i % 2 == 0);
            tick();
            if (o_led && !prev_led) pulses++;
            prev_led = o_led;
            total++;
            if (gotv() !== expv()) $display("FAIL overflow cyc=%0d got=%b exp=%b", i, gotv(), expv());
            else passed++;
        end
        total++;
        if (pulses !== 3) $display("FAIL overflow_pulses got=%0d exp=%0d", pulses, 3);
        else passed++;
        drain();
    endtask

    task automatic test_gap_edge_event();
        bit lv [0:8] = '{1, 0, 1, 0, 0, 0, 0, 1, 0};
        int pulses = 0;
        bit prev_led = 1'b0;
        for (int i = 0; i < 30; i++) begin
            i_event = (i < 9) ? lv[i] : 1'b0;
            tick();
            if (o_led && !prev_led) pulses++;
            prev_led = o_led;
            total++;
            if (gotv() !== expv()) $display("FAIL gap_edge cyc=%0d got=%b exp=%b", i, gotv(), expv());
            else passed++;
            if (i == 7) begin
                total++;
                if (o_pending !== 2'd1 || o_led !== 1'b1)
                    $display("FAIL gap_edge_pop_push got=%0d/%b exp=1/1", o_pending, o_led);
                else passed++;
            end
        end
        total++;
        if (pulses !== 3) $display("FAIL gap_edge_pulses got=%0d exp=%0d", pulses, 3);
        else passed++;
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            i_event = (i % 2 == 0);
            tick();
            total++;
            if (gotv() !== expv()) $display("FAIL reset_mid_fill cyc=%0d got=%b exp=%b", i, gotv(), expv());
            else passed++;
        end
        total++;
        if (gotv() !== 5'b1_1_10_1) $display("FAIL reset_mid_pre got=%b exp=%b", gotv(), 5'b1_1_10_1);
        else passed++;
        i_event = 1'b0;
        i_rst_n = 1'b0;
        tick();
        total++;
        if (gotv() !== 5'b0) $display("FAIL reset_mid_post got=%b exp=%b", gotv(), 5'b0);
        else passed++;
        i_rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            total++;
            if (gotv() !== 5'b0 || expv() !== 5'b0)
                $display("FAIL reset_mid_idle cyc=%0d got=%b exp=%b", i, gotv(), 5'b0);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            i_rst_n = ($urandom_range(0, 299) != 0);
            if (i % 400 < 200) i_event = ($urandom_range(0, 2) == 0);
            else               i_event = ($urandom_range(0, 12) == 0);
            tick();
            total++;
            if (gotv() !== expv()) $display("FAIL random cyc=%0d got=%b exp=%b", i, gotv(), expv());
            else passed++;
        end
        i_rst_n = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_events();
        test_overflow();
        test_gap_edge_event();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
